// File: rtl/spi_pkg.sv
// Shared SPI definitions: address width, r/w bit encoding and master FSM states.
package spi_pkg;

  localparam int   ADR_W        = 7;
  localparam logic RW_WRITE     = 1'b1;
  localparam logic RW_READ      = 1'b0;
  localparam int   MIN_HALF_DIV = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT_HI = 3'd2,
    SHIFT_LO = 3'd3,
    CS_HOLD  = 3'd4,
    GAP      = 3'd5
  } state_e;

  // Bits in one frame: r/w flag, address, data field.
  function automatic int frame_bits(input int nbit);
    return 1 + ADR_W + nbit;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Terminal-count divider: counts 0..DIV-1 and ticks on the last count.
// clr holds the count at zero and suppresses the tick.
module spi_half_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/spi_master_write.sv
// SPI master: sends {rw, adr, wdata} MSB first on cs/sclk/mosi, all outputs registered.
// Optional read frames (rw=0, miso captured into rdata) are built when SPI_READ_EN is defined.
module spi_master_write
  import spi_pkg::*;
#(
  parameter int Nbit     = 8,
  parameter int HALF_DIV = 4,
  parameter int CS_GAP   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADR_W-1:0] adr,
  input  logic             rw,
  input  logic [Nbit-1:0]  wdata,
  output logic             busy,
  output logic             done,
  output logic [Nbit-1:0]  rdata,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso
);

  localparam int            TOT      = frame_bits(Nbit);
  localparam int            BW       = $clog2(TOT);
  localparam logic [BW-1:0] LAST_BIT = BW'(TOT - 1);

  if (HALF_DIV < MIN_HALF_DIV) begin : g_div_check
    $error("spi_master_write: HALF_DIV must be at least %0d", MIN_HALF_DIV);
  end

  state_e         state, state_nxt;
  logic [TOT-1:0] sr;
  logic [BW-1:0]  bit_cnt;
  logic           half_tick, gap_tick, rw_eff, accept, in_frame, frame_end;
  logic           half_clr, gap_clr;
  logic           cs_nxt, sclk_nxt, mosi_nxt, busy_nxt, done_nxt;

  assign in_frame  = (state == CS_SETUP) || (state == SHIFT_HI) ||
                     (state == SHIFT_LO) || (state == CS_HOLD);
  assign accept    = (state == IDLE) && start && !busy;
  assign frame_end = (state == GAP) && gap_tick;
  assign half_clr  = !in_frame;
  assign gap_clr   = (state != GAP);

  spi_half_tick #(.DIV(HALF_DIV)) u_half (
    .clk(clk), .rst(rst), .clr(half_clr), .tick(half_tick)
  );

  spi_half_tick #(.DIV(CS_GAP)) u_gap (
    .clk(clk), .rst(rst), .clr(gap_clr), .tick(gap_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = CS_SETUP; else state_nxt = IDLE;
      CS_SETUP: if (half_tick) state_nxt = SHIFT_HI; else state_nxt = CS_SETUP;
      SHIFT_HI: if (half_tick) state_nxt = SHIFT_LO; else state_nxt = SHIFT_HI;
      SHIFT_LO: begin
        if (half_tick) state_nxt = (bit_cnt == LAST_BIT) ? CS_HOLD : SHIFT_HI;
        else           state_nxt = SHIFT_LO;
      end
      CS_HOLD:  if (half_tick) state_nxt = GAP; else state_nxt = CS_HOLD;
      GAP:      if (gap_tick) state_nxt = IDLE; else state_nxt = GAP;
      default:  state_nxt = IDLE;
    endcase
  end

  // busy stays high through the done cycle so a start is only taken the cycle after.
  always_comb begin
    cs_nxt   = !((state_nxt == CS_SETUP) || (state_nxt == SHIFT_HI) ||
                 (state_nxt == SHIFT_LO) || (state_nxt == CS_HOLD));
    sclk_nxt = (state_nxt == SHIFT_HI);
    busy_nxt = (state_nxt != IDLE) || frame_end;
    done_nxt = frame_end;
    if (accept) begin
      mosi_nxt = rw_eff;
    end else if ((state == SHIFT_HI) && half_tick) begin
      mosi_nxt = sr[TOT-2];
    end else begin
      mosi_nxt = mosi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs   <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cs   <= cs_nxt;
      sclk <= sclk_nxt;
      mosi <= mosi_nxt;
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

  // Frame shift register shifts as sclk falls; bit counter advances at the end of each low phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sr      <= {rw_eff, adr, (rw_eff == RW_WRITE) ? wdata : {Nbit{1'b0}}};
      bit_cnt <= '0;
    end else if ((state == SHIFT_HI) && half_tick) begin
      sr      <= {sr[TOT-2:0], 1'b0};
    end else if ((state == SHIFT_LO) && half_tick) begin
      bit_cnt <= bit_cnt + BW'(1);
    end
  end

`ifdef SPI_READ_EN
  logic [Nbit-1:0] rsr;
  logic            rd;

  assign rw_eff = rw;

  // miso is sampled at the end of each high phase; the newest Nbit samples are the data field.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsr   <= '0;
      rd    <= 1'b0;
      rdata <= '0;
    end else begin
      if (accept) rd <= (rw == RW_READ);
      if ((state == SHIFT_HI) && half_tick) rsr <= Nbit'({rsr, miso});
      if (frame_end && rd) rdata <= rsr;
    end
  end
`else
  logic unused_in;

  assign rw_eff    = RW_WRITE;
  assign rdata     = '0;
  assign unused_in = miso ^ rw;
`endif

endmodule

// File: tb/tb_spi_master_write.sv
// Bench for spi_master_write: cycle-arithmetic reference model checked every cycle,
// directed frames, randomized frames with mid-frame noise/resets, and a second geometry.
module tb_spi_master_write;

  localparam int NB    = 8;
  localparam int H     = 4;
  localparam int G     = 8;
  localparam int TOT   = 8 + NB;
  localparam int CSLOW = H * (2 * TOT + 2);
  localparam int DONEK = 1 + CSLOW + G;
`ifdef SPI_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, rw, miso;
  logic [6:0] adr;
  logic [NB-1:0] wdata, rdata;
  logic busy, done, cs, sclk, mosi;

  logic start2;
  logic [15:0] wdata2, rdata2;
  logic busy2, done2, cs2, sclk2, mosi2;

  spi_master_write #(.Nbit(NB), .HALF_DIV(H), .CS_GAP(G)) dut (
    .clk(clk), .rst(rst), .start(start), .adr(adr), .rw(rw), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_master_write #(.Nbit(16), .HALF_DIV(6), .CS_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .adr(7'h01), .rw(1'b1), .wdata(wdata2),
    .busy(busy2), .done(done2), .rdata(rdata2), .cs(cs2), .sclk(sclk2), .mosi(mosi2), .miso(1'b1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model: frame start cycle and captured frame contents
  int cyc = 0;
  int m_t0 = 0;
  bit m_active = 1'b0;
  bit m_read = 1'b0;
  logic [TOT-1:0] m_frame = '0;
  logic [TOT-1:0] m_miso = '1;
  logic [TOT-1:0] next_miso = '1;
  logic [NB-1:0] m_rdata = '0;

  // observers
  logic cs_p = 1'b1, sclk_p = 1'b0, cs2_p = 1'b1, sclk2_p = 1'b0;
  int edges = 0, edges2 = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  int done2_cnt = 0, done2_cyc = 0, cslow2 = 0, busy2_cnt = 0;
  logic [63:0] stream = '0, stream2 = '0;
  logic [7:0] slave_out = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    int k, idx;
    logic e_cs, e_sclk, e_mosi, e_busy, e_done;
    k = cyc - m_t0 + 1;
    e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_active && k >= 1 && k <= DONEK) begin
      e_busy = 1'b1;
      e_done = (k == DONEK);
      e_cs   = (k > CSLOW);
      e_sclk = (k > H) && (k - 1 - H < 2 * H * TOT) && (((k - 1 - H) / H) % 2 == 0);
      idx    = (k - 1) / (2 * H);
      e_mosi = (idx < TOT) ? m_frame[TOT-1-idx] : 1'b0;
    end
    check("cs", cs, e_cs);
    check("sclk", sclk, e_sclk);
    check("mosi", mosi, e_mosi);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("rdata", rdata, m_rdata);
  endtask

  task automatic drive_miso();
    int k, idx;
    k = cyc - m_t0 + 1;
    idx = (k - 1) / (2 * H);
    if (m_active && k >= 1 && idx < TOT) miso = m_miso[TOT-1-idx];
    else miso = 1'b1;
  endtask

  task automatic monitor();
    if (!cs && cs_p) begin edges = 0; stream = '0; end
    if (sclk && !sclk_p) begin edges++; stream = {stream[62:0], mosi}; end
    if (cs && !cs_p && edges == TOT && stream[15:8] == 8'h81) slave_out = stream[7:0];
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    cs_p = cs; sclk_p = sclk;
    if (!cs2 && cs2_p) begin edges2 = 0; stream2 = '0; end
    if (sclk2 && !sclk2_p) begin edges2++; stream2 = {stream2[62:0], mosi2}; end
    if (!cs2) cslow2++;
    if (busy2) busy2_cnt++;
    if (done2) begin done2_cnt++; done2_cyc = cyc; end
    cs2_p = cs2; sclk2_p = sclk2;
  endtask

  task automatic model_edge();
    bit b;
    logic rwe;
    b = m_active && (cyc - m_t0 + 1) >= 1 && (cyc - m_t0 + 1) <= DONEK;
    cyc++;
    if (rst) begin
      m_active = 1'b0;
      m_rdata = '0;
    end else begin
      if (m_active && m_read && (cyc - m_t0 + 1) == DONEK) m_rdata = m_miso[NB-1:0];
      if (start && !b) begin
        rwe = READ_EN ? rw : 1'b1;
        m_active = 1'b1;
        m_t0 = cyc;
        m_read = !rwe;
        m_frame = {rwe, adr, rwe ? wdata : {NB{1'b0}}};
        m_miso = next_miso;
      end
    end
  endtask

  // one clock: check at falling edge, update model, return just after the rising edge
  task automatic step();
    @(negedge clk);
    check_cycle();
    monitor();
    drive_miso();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [6:0] a, input logic r, input logic [NB-1:0] d, output int lat);
    int t0, d0;
    adr = a; rw = r; wdata = d; start = 1'b1;
    t0 = cyc; d0 = done_cnt;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && done_cnt == d0; i++) step();
    check("frame_timeout", done_cnt - d0, 1);
    lat = done_cyc - t0;
  endtask

  initial begin
    int lat, d0, b0, t0, len;
    rst = 1'b1; start = 1'b0; adr = '0; rw = 1'b1; wdata = '0; miso = 1'b1;
    start2 = 1'b0; wdata2 = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_cs", cs, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_sclk", sclk, 1'b0);

    run_frame(7'h01, 1'b1, 8'hA5, lat);
    check("a5_latency", lat, 145);
    check("a5_edges", edges, 16);
    check("a5_stream", stream[15:0], 16'h81A5);
    check("a5_slave", slave_out, 8'hA5);

    run_frame(7'h02, 1'b1, 8'h5A, lat);
    check("adr2_latency", lat, 145);
    check("adr2_stream", stream[15:0], 16'h825A);
    check("adr2_slave", slave_out, 8'hA5);

    // start held three cycles, then pulsed again mid-frame
    d0 = done_cnt; b0 = busy_cnt;
    adr = 7'h03; rw = 1'b1; wdata = 8'hC3; start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    repeat (50) step();
    start = 1'b1; step(); start = 1'b0;
    repeat (200) step();
    check("held_start_dones", done_cnt - d0, 1);
    check("held_start_busy", busy_cnt - b0, 145);

    // reset 40 cycles into a frame, new start two cycles after reset
    d0 = done_cnt;
    adr = 7'h01; wdata = 8'hFF; start = 1'b1;
    step(); start = 1'b0;
    repeat (39) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("abort_cs", cs, 1'b1);
    check("abort_sclk", sclk, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    step();
    run_frame(7'h01, 1'b1, 8'h3C, lat);
    check("after_abort_latency", lat, 145);
    check("after_abort_stream", stream[15:0], 16'h813C);
    check("after_abort_dones", done_cnt - d0, 1);

`ifdef SPI_READ_EN
    next_miso = {8'hF0, 8'h3C};
    run_frame(7'h05, 1'b0, 8'hFF, lat);
    check("read_rdata", rdata, 8'h3C);
    check("read_stream", stream[15:0], 16'h0500);
    check("read_latency", lat, 145);
`endif

    // randomized frames with input noise, stray starts and occasional resets
    for (int f = 0; f < 40; f++) begin
      next_miso = TOT'({$urandom, $urandom});
      adr = 7'($urandom); rw = 1'($urandom); wdata = NB'($urandom);
      start = 1'b1; d0 = done_cnt;
      step();
      if ($urandom_range(0, 7) == 0) begin
        len = $urandom_range(1, DONEK);
        for (int i = 0; i < len; i++) begin
          adr = 7'($urandom); wdata = NB'($urandom); rw = 1'($urandom);
          start = ($urandom_range(0, 7) == 0);
          step();
        end
        start = 1'b0; rst = 1'b1; step(); rst = 1'b0;
      end else begin
        for (int i = 0; i < 400 && done_cnt == d0; i++) begin
          adr = 7'($urandom); wdata = NB'($urandom); rw = 1'($urandom);
          start = ($urandom_range(0, 7) == 0);
          step();
        end
        check("rand_timeout", done_cnt - d0, 1);
        start = 1'b0;
      end
      repeat ($urandom_range(0, 3)) step();
    end
    start = 1'b0;
    repeat (DONEK + 5) step();

    // second geometry: Nbit=16, HALF_DIV=6, CS_GAP=2
    wdata2 = 16'h8001; start2 = 1'b1; t0 = cyc; cslow2 = 0; busy2_cnt = 0;
    step(); start2 = 1'b0;
    for (int i = 0; i < 800 && done2_cnt == 0; i++) step();
    step();
    check("g2_done_count", done2_cnt, 1);
    check("g2_latency", done2_cyc - t0, 303);
    check("g2_edges", edges2, 24);
    check("g2_stream", stream2[23:0], 24'h818001);
    check("g2_cs_low", cslow2, 300);
    check("g2_busy", busy2_cnt, 303);
    check("g2_rdata", rdata2, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_master_write.md
Name: spi_master_write

Overview:
- SPI master that drives the register-write slaves on the board-level SPI bus: generates cs, sclk and mosi from the system clock.
- Frame format: one address byte, MSB first (bit7 = r_w with 1 = write, bits6:0 = slave address), then Nbit data bits, MSB first.
- Slaves sample mosi on rising sclk through a 3-flop synchroniser. Every sclk phase therefore lasts several clk cycles.

Parameters:
- Nbit, 8, data field width in bits (1..32).
- HALF_DIV, 4, clk cycles per sclk half-period. Must be >=4; elaboration error (generate-time $error) if smaller.
- CS_GAP, 8, clk cycles cs is held high after a frame before done/ready.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  request pulse, sampled only when busy=0
- adr  in  7  target slave address
- rw  in  1  1 = write, 0 = read (read only with SPI_READ_EN)
- wdata  in  Nbit  data to send
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of frame
- rdata  out  Nbit  read result (SPI_READ_EN only)
- cs  out  1  chip select, active low
- sclk  out  1  serial clock, idle low
- mosi  out  1  serial data out
- miso  in  1  serial data in, idles high

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: cs=1, sclk=0, mosi=0, busy=0, done=0, rdata=0, state=IDLE. rst has priority over every other event, including mid-frame. The frame is abandoned with cs high at the next clk edge.
- Shift register: SR of width 8+Nbit, loaded with {rw, adr, wdata} on an accepted start. rw is forced to 1 without SPI_READ_EN.
- Bit counter: 0..8+Nbit-1.
- Half-period counter: counts 0..HALF_DIV-1 and issues a tick on the terminal count.
- IDLE:
  - start=1 -> load SR, cs<=0, busy<=1, mosi<=SR MSB, go to CS_SETUP.
  - start while busy=1 is ignored (no queueing).
- CS_SETUP: HALF_DIV cycles with sclk=0, then go to SHIFT_HI.
- SHIFT_HI:
  - sclk=1 for HALF_DIV cycles.
  - On the last cycle, sample miso into the read shift register (read only).
  - Then go to SHIFT_LO.
- SHIFT_LO:
  - sclk=0 for HALF_DIV cycles.
  - On entry, shift SR left and drive the next bit on mosi.
  - After bit 8+Nbit-1, go to CS_HOLD; otherwise go to SHIFT_HI.
- CS_HOLD: HALF_DIV cycles with sclk=0 and mosi=0, then cs<=1 and go to GAP.
- GAP: CS_GAP cycles with cs=1, then done=1 for one cycle, busy<=0, go to IDLE.
- Timing:
  - First cs-low cycle is start cycle +1.
  - done is asserted exactly 1 + HALF_DIV*(2*(8+Nbit)+2) + CS_GAP cycles after the start cycle: 145 with default parameters.
  - A new start is accepted in the cycle after done.
- Each mosi bit is stable for the full sclk-high phase and for at least HALF_DIV cycles before its rising edge.
- mosi never changes while sclk=1.
- Inputs adr/rw/wdata are captured only at start; later changes have no effect on the running frame.

Optional Feature:
- Macro: SPI_READ_EN.
- Defined:
  - rw=0 sends address byte bit7=0; mosi=0 for all data bits.
  - The last Nbit miso samples (MSB first) load rdata when done is asserted.
  - rdata keeps its value until the next read completes; write frames leave it unchanged.
- Undefined:
  - rw is ignored (every frame is a write).
  - miso is unused; rdata is constant 0.

Decomposition:
- Shared package spi_pkg:
  - ADR_W=7, RW_WRITE=1'b1, RW_READ=1'b0, MIN_HALF_DIV=4.
  - State encoding IDLE, CS_SETUP, SHIFT_HI, SHIFT_LO, CS_HOLD, GAP.
- Sub-module spi_half_tick: the HALF_DIV counter with synchronous clear and a tick output. It is reused by future SPI blocks.

Test Plan:
- Default params, start with adr=7'h01, rw=1, wdata=8'hA5:
  - Serial stream is 1000_0001 1010_0101 on rising sclk.
  - 16 rising edges.
  - done at cycle +145.
  - Loopback to the existing write slave (param_adr=1) gives out=8'hA5.
- Same frame with adr=7'h02: the param_adr=1 slave output stays unchanged; master timing is identical.
- start held high for 3 cycles, then pulsed again mid-frame: exactly one frame, one done pulse, busy continuous.
- rst asserted at cycle 40 of a frame:
  - Next cycle cs=1, sclk=0, busy=0, no done.
  - A start issued 2 cycles later yields a correct full frame.
- SPI_READ_EN, rw=0, miso model returns 8'h3C on the data bits: rdata=8'h3C at done; mosi=0 during the data phase.
- Nbit=16, HALF_DIV=6, CS_GAP=2, wdata=16'h8001:
  - 24 rising edges.
  - done at 1+6*50+2 = 303 cycles.
  - cs low for 6*50 = 300 cycles.
